// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch stage and reusable by decode.
package instruction_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INC =
    32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC =
    32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } fetch_pkt_t;

endpackage

// File: rtl/pc_next_sel.sv
// Fetch address priority mux and sequential +4 adder.
// Ports: redirect/stall controls, held PCs in; imem_addr, next_pc out.
module pc_next_sel
  import instruction_fetch_pkg::*;
(
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              resp_valid,
  input  logic              out_ready,
  input  logic [ADDR_W-1:0] resp_pc,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] next_pc
);

  logic stall;

  // Stall only matters when no redirect is pending,
  // which keeps the case items mutually exclusive.
  assign stall = !redirect_valid && resp_valid && !out_ready;

  always_comb begin
    imem_addr = fetch_pc;
    unique case (1'b1)
      redirect_valid:
        imem_addr = {redirect_target[ADDR_W-1:2], 2'b00};
      stall:
        imem_addr = resp_pc;
      default:
        imem_addr = fetch_pc;
    endcase
  end

  assign next_pc = imem_addr + PC_INC;

endmodule

// File: rtl/instruction_fetch.sv
// PC/fetch-control stage pairing imem words with their PC for decode.
// Ports: clk, reset_n, imem_addr/imem_data, redirect, out_* handshake, fetch_count.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic [31:0] fetch_count
);

  localparam logic [29:0] WORD_LIM = 30'(IMEM_WORDS);

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic [31:0] next_pc;
  logic        fire;
  fetch_pkt_t  pkt;

  pc_next_sel u_sel (
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .resp_valid      (resp_valid),
    .out_ready       (out_ready),
    .resp_pc         (resp_pc),
    .fetch_pc        (fetch_pc),
    .imem_addr       (imem_addr),
    .next_pc         (next_pc)
  );

  assign fire = resp_valid & out_ready;

  // Every cycle issues an address, so the word on imem_data
  // is always live unless we are coming out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      resp_valid  <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      fetch_pc    <= next_pc;
      resp_pc     <= imem_addr;
      resp_valid  <= 1'b1;
      fetch_count <= fetch_count + {31'd0, fire};
    end
  end

  assign pkt.pc    = resp_pc;
  assign pkt.instr = imem_data;
  assign pkt.fault = resp_valid & (resp_pc[31:2] >= WORD_LIM);

  assign out_valid = resp_valid;
  assign out_pc    = pkt.pc;
  assign out_instr = pkt.instr;
  assign out_fault = pkt.fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a handshake scoreboard.
// Memory model returns 0x1000 + word index for any address.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic [31:0] fetch_count;

  int total  = 0;
  int passed = 0;
  fetch_pkt_t sb[$];

  instruction_fetch dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_fault       (out_fault),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_data <= 32'h1000 + {2'b00, imem_addr[31:2]};

  task automatic chk(input string tag,
                     input logic [64:0] obs,
                     input logic [64:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  function automatic void push(input logic [31:0] pc,
                               input logic f);
    fetch_pkt_t p;
    p.pc    = pc;
    p.instr = 32'h1000 + {2'b00, pc[31:2]};
    p.fault = f;
    sb.push_back(p);
  endfunction

  // One clock: drive inputs, check address, score a handshake.
  task automatic cyc(input logic rdy,
                     input logic rv,
                     input logic [31:0] tgt,
                     input logic [31:0] exp_addr);
    fetch_pkt_t e;
    fetch_pkt_t got;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    chk("imem_addr", 65'(imem_addr), 65'(exp_addr));
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 65'(sb.size() > 0), 65'(1));
      if (sb.size() > 0) begin
        e         = sb.pop_front();
        got.pc    = out_pc;
        got.instr = out_instr;
        got.fault = out_fault;
        chk("handshake", got, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n         = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", 65'(out_valid), 65'(0));
    chk("rst_fault", 65'(out_fault), 65'(0));
    chk("rst_addr", 65'(imem_addr), 65'(0));
    chk("rst_count", 65'(fetch_count), 65'(0));
    reset_n = 1'b1;

    // streaming
    chk("first_valid", 65'(out_valid), 65'(0));
    cyc(1, 0, 0, 32'd0);
    chk("lat_valid", 65'(out_valid), 65'(1));
    chk("lat_pc", 65'(out_pc), 65'(0));
    push(32'd0, 0);
    cyc(1, 0, 0, 32'd4);
    push(32'd4, 0);
    cyc(1, 0, 0, 32'd8);
    push(32'd8, 0);
    cyc(1, 0, 0, 32'd12);
    push(32'd12, 0);
    cyc(1, 0, 0, 32'd16);
    chk("count4", 65'(fetch_count), 65'(4));

    // redirect back to 8 while accepting 16
    push(32'd16, 0);
    cyc(1, 1, 32'd8, 32'd8);
    chk("redir8_pc", 65'(out_pc), 65'(8));

    // stall three cycles at pc 8
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 32'd8);
      chk("stall_pc", 65'(out_pc), 65'(8));
      chk("stall_instr", 65'(out_instr), 65'(32'h1002));
      chk("stall_valid", 65'(out_valid), 65'(1));
    end
    chk("stall_count", 65'(fetch_count), 65'(5));
    push(32'd8, 0);
    cyc(1, 0, 0, 32'd12);
    chk("resume_pc", 65'(out_pc), 65'(12));
    chk("count6", 65'(fetch_count), 65'(6));

    // redirect without fire drops pc 12
    cyc(0, 1, 32'h40, 32'h40);
    chk("rnf_pc", 65'(out_pc), 65'(32'h40));
    chk("rnf_instr", 65'(out_instr), 65'(32'h1010));
    chk("rnf_count", 65'(fetch_count), 65'(6));

    // redirect with fire, misaligned target
    push(32'h40, 0);
    cyc(1, 0, 0, 32'h44);
    push(32'h44, 0);
    cyc(1, 1, 32'h43, 32'h40);
    chk("rwf_pc", 65'(out_pc), 65'(32'h40));
    chk("rwf_count", 65'(fetch_count), 65'(8));

    // range edge
    push(32'h40, 0);
    cyc(1, 1, 32'hFFC, 32'hFFC);
    chk("last_pc", 65'(out_pc), 65'(32'hFFC));
    chk("last_fault", 65'(out_fault), 65'(0));
    push(32'hFFC, 0);
    cyc(1, 0, 0, 32'h1000);
    chk("oob_pc", 65'(out_pc), 65'(32'h1000));
    chk("oob_fault", 65'(out_fault), 65'(1));

    // wrap
    push(32'h1000, 1);
    cyc(1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    chk("top_fault", 65'(out_fault), 65'(1));
    push(32'hFFFF_FFFC, 1);
    cyc(1, 0, 0, 32'd0);
    chk("wrap_pc", 65'(out_pc), 65'(0));
    chk("wrap_fault", 65'(out_fault), 65'(0));
    chk("count12", 65'(fetch_count), 65'(12));

    // reset mid-stall at 0x20
    cyc(0, 1, 32'h20, 32'h20);
    cyc(0, 0, 0, 32'h20);
    chk("pre_rst_pc", 65'(out_pc), 65'(32'h20));
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", 65'(out_valid), 65'(0));
    chk("mrst_fault", 65'(out_fault), 65'(0));
    chk("mrst_addr", 65'(imem_addr), 65'(0));
    chk("mrst_count", 65'(fetch_count), 65'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rel_valid", 65'(out_valid), 65'(0));
    cyc(1, 0, 0, 32'd0);
    chk("rel_pc", 65'(out_pc), 65'(0));
    chk("rel_valid2", 65'(out_valid), 65'(1));
    push(32'd0, 0);
    cyc(1, 0, 0, 32'd4);
    chk("rel_count", 65'(fetch_count), 65'(1));

    chk("sb_empty", 65'(sb.size()), 65'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
